// File: rtl/instruction_register.sv
// Instruction register: captures opcode plus two operand bytes from fetch
// and presents them as one packed word and as individual fields, with a
// valid flag that the control unit can squash via flush.
module instruction_register #(
  parameter  int unsigned DATA_W = 8,
  localparam int unsigned INST_W = 3 * DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] opcode,
  input  logic [DATA_W-1:0] operando1,
  input  logic [DATA_W-1:0] operando2,
  output logic [INST_W-1:0] instReg,
  output logic [DATA_W-1:0] opcode_q,
  output logic [DATA_W-1:0] operando1_q,
  output logic [DATA_W-1:0] operando2_q,
  output logic              valid
);

  // Packed instruction word; field order fixes opcode in the top byte.
  typedef struct packed {
    logic [DATA_W-1:0] opcode;
    logic [DATA_W-1:0] operando1;
    logic [DATA_W-1:0] operando2;
  } inst_t;

  inst_t inst_q;
  inst_t inst_d;
  logic  valid_q;

  // Assemble the incoming word from the fetch bytes.
  always_comb begin
    inst_d           = '0;
    inst_d.opcode    = opcode;
    inst_d.operando1 = operando1;
    inst_d.operando2 = operando2;
  end

  // Storage: reset and flush clear, load captures, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q  <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      inst_q  <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      inst_q  <= inst_d;
      valid_q <= 1'b1;
    end
  end

  // Packed word and field views all come from the single storage register.
  assign instReg     = INST_W'(inst_q);
  assign opcode_q    = inst_q.opcode;
  assign operando1_q = inst_q.operando1;
  assign operando2_q = inst_q.operando2;
  assign valid       = valid_q;

endmodule

// File: tb/tb_instruction_register.sv
// Directed self-checking bench for instruction_register.
module tb_instruction_register;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic        flush;
  logic [7:0]  opcode;
  logic [7:0]  operando1;
  logic [7:0]  operando2;
  logic [23:0] instReg;
  logic [7:0]  opcode_q;
  logic [7:0]  operando1_q;
  logic [7:0]  operando2_q;
  logic        valid;

  int checks = 0;
  int errors = 0;

  instruction_register #(.DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .flush       (flush),
    .opcode      (opcode),
    .operando1   (operando1),
    .operando2   (operando2),
    .instReg     (instReg),
    .opcode_q    (opcode_q),
    .operando1_q (operando1_q),
    .operando2_q (operando2_q),
    .valid       (valid)
  );

  // 10-unit clock period, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b1; flush = 1'b0;
    opcode = 8'hFF; operando1 = 8'hFF; operando2 = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (instReg !== 24'h000000) begin
      errors++; $display("FAIL reset_inst: got %h expected %h", instReg, 24'h000000);
    end
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected %b", valid, 1'b0);
    end
    checks++;
    if ({opcode_q, operando1_q, operando2_q} !== 24'h000000) begin
      errors++; $display("FAIL reset_fields: got %h %h %h expected 00 00 00",
                         opcode_q, operando1_q, operando2_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (instReg !== 24'hFFFFFF) begin
      errors++; $display("FAIL first_load_inst: got %h expected %h", instReg, 24'hFFFFFF);
    end
    checks++;
    if (valid !== 1'b1) begin
      errors++; $display("FAIL first_load_valid: got %b expected %b", valid, 1'b1);
    end
  endtask

  task automatic test_staggered();
    logic [23:0] exp_word [4];
    exp_word[0] = 24'h000000;
    exp_word[1] = 24'h010000;
    exp_word[2] = 24'h010100;
    exp_word[3] = 24'h010101;
    load = 1'b1; flush = 1'b0;
    opcode = 8'h00; operando1 = 8'h00; operando2 = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) opcode    = 8'h01;
      if (i == 2) operando1 = 8'h01;
      if (i == 3) operando2 = 8'h01;
      @(posedge clk); #1;
      checks++;
      if (instReg !== exp_word[i]) begin
        errors++; $display("FAIL stagger_inst[%0d]: got %h expected %h", i, instReg, exp_word[i]);
      end
      checks++;
      if ({opcode_q, operando1_q, operando2_q} !== exp_word[i]) begin
        errors++; $display("FAIL stagger_fields[%0d]: got %h%h%h expected %h",
                           i, opcode_q, operando1_q, operando2_q, exp_word[i]);
      end
    end
  endtask

  task automatic test_hold();
    load = 1'b1; flush = 1'b0;
    opcode = 8'hA5; operando1 = 8'h3C; operando2 = 8'h7E;
    @(posedge clk); #1;
    checks++;
    if (instReg !== 24'hA53C7E) begin
      errors++; $display("FAIL hold_capture: got %h expected %h", instReg, 24'hA53C7E);
    end
    load = 1'b0;
    opcode = 8'h00; operando1 = 8'h00; operando2 = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (instReg !== 24'hA53C7E || valid !== 1'b1) begin
        errors++; $display("FAIL hold_cycle[%0d]: got %h/%b expected %h/%b",
                           i, instReg, valid, 24'hA53C7E, 1'b1);
      end
    end
    checks++;
    if (opcode_q !== 8'hA5 || operando1_q !== 8'h3C || operando2_q !== 8'h7E) begin
      errors++; $display("FAIL hold_fields: got %h %h %h expected a5 3c 7e",
                         opcode_q, operando1_q, operando2_q);
    end
  endtask

  task automatic test_flush_priority();
    load = 1'b1; flush = 1'b0;
    opcode = 8'h12; operando1 = 8'h34; operando2 = 8'h56;
    @(posedge clk); #1;
    checks++;
    if (instReg !== 24'h123456 || valid !== 1'b1) begin
      errors++; $display("FAIL flush_setup: got %h/%b expected %h/%b", instReg, valid, 24'h123456, 1'b1);
    end
    flush = 1'b1;
    opcode = 8'hAA; operando1 = 8'hAA; operando2 = 8'hAA;
    @(posedge clk); #1;
    checks++;
    if (instReg !== 24'h000000) begin
      errors++; $display("FAIL flush_inst: got %h expected %h", instReg, 24'h000000);
    end
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL flush_valid: got %b expected %b", valid, 1'b0);
    end
    checks++;
    if ({opcode_q, operando1_q, operando2_q} !== 24'h000000) begin
      errors++; $display("FAIL flush_fields: got %h%h%h expected 000000",
                         opcode_q, operando1_q, operando2_q);
    end
    flush = 1'b0; load = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (instReg !== 24'h000000 || valid !== 1'b0) begin
      errors++; $display("FAIL flush_hold: got %h/%b expected %h/%b", instReg, valid, 24'h000000, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    load = 1'b1; flush = 1'b0;
    opcode = 8'h0F; operando1 = 8'h0F; operando2 = 8'h0F;
    @(posedge clk); #1;
    checks++;
    if (instReg !== 24'h0F0F0F || valid !== 1'b1) begin
      errors++; $display("FAIL async_setup: got %h/%b expected %h/%b", instReg, valid, 24'h0F0F0F, 1'b1);
    end
    // Drop reset between edges; outputs must clear before the next edge.
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (instReg !== 24'h000000 || valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: got %h/%b expected %h/%b", instReg, valid, 24'h000000, 1'b0);
    end
    @(posedge clk); #1;
    checks++;
    if (instReg !== 24'h000000 || valid !== 1'b0) begin
      errors++; $display("FAIL async_reset_held: got %h/%b expected %h/%b", instReg, valid, 24'h000000, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    load = 1'b1; flush = 1'b0;
    opcode = 8'h10; operando1 = 8'h20; operando2 = 8'h30;
    @(posedge clk); #1;
    checks++;
    if (instReg !== 24'h102030 || valid !== 1'b1) begin
      errors++; $display("FAIL b2b_first: got %h/%b expected %h/%b", instReg, valid, 24'h102030, 1'b1);
    end
    opcode = 8'h40; operando1 = 8'h50; operando2 = 8'h60;
    @(posedge clk); #1;
    checks++;
    if (instReg !== 24'h405060 || valid !== 1'b1) begin
      errors++; $display("FAIL b2b_second: got %h/%b expected %h/%b", instReg, valid, 24'h405060, 1'b1);
    end
    checks++;
    if (opcode_q !== 8'h40 || operando1_q !== 8'h50 || operando2_q !== 8'h60) begin
      errors++; $display("FAIL b2b_fields: got %h %h %h expected 40 50 60",
                         opcode_q, operando1_q, operando2_q);
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_staggered();
    test_hold();
    test_flush_priority();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_register.md
Name: instruction_register

Overview:
- Instruction Register (IR) of the microprocessor datapath.
- Captures the 8-bit opcode and two 8-bit operands presented by the fetch logic on a rising clock edge.
- Holds them as one packed 24-bit instruction word, plus individual field outputs, for the decoder and control unit.
- Provides load, flush and valid signalling so the control FSM can stall or squash the held instruction.

Parameters:
- DATA_W, 8, width of each field (opcode, operando1, operando2).
- INST_W, 3*DATA_W (24), width of packed instReg. Derived; must not be overridden independently.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  capture enable. 1 = capture inputs on this edge; 0 = hold.
- flush  input  1  synchronous squash of the held instruction.
- opcode  input  DATA_W  opcode byte from fetch.
- operando1  input  DATA_W  first operand byte.
- operando2  input  DATA_W  second operand byte.
- instReg  output  INST_W  registered packed word {opcode, operando1, operando2}, opcode in bits [23:16].
- opcode_q  output  DATA_W  registered opcode, equal to instReg[23:16].
- operando1_q  output  DATA_W  registered operand 1, equal to instReg[15:8].
- operando2_q  output  DATA_W  registered operand 2, equal to instReg[7:0].
- valid  output  1  1 while the register holds a captured, unflushed instruction.

Behaviour:
- Reset: rst_n low asynchronously forces instReg=24'h000000, all field outputs 0, valid=0, regardless of clk. Outputs stay at these values while rst_n is low.
- Reset release: the first capture can occur on the first rising edge with rst_n high.
- Capture (load=1, flush=0): on rising clk, instReg <= {opcode, operando1, operando2}; valid <= 1.
  - Latency is one cycle; outputs change only after the edge, never combinationally from inputs.
  - Each input byte is captured independently. An input changing between edges affects only the next captured word.
  - Undriven or unknown input bits are captured as-is. No masking.
- Hold (load=0, flush=0): all outputs retain their value; valid unchanged.
- Flush (flush=1): on rising clk, instReg <= 0, fields <= 0, valid <= 0. Flush has priority over load when both are asserted on the same edge.
- Field outputs are always bit-identical to the corresponding slices of instReg. Implement them from the same storage; no separate copies.
- Back-to-back loads capture a new word every cycle with no bubble.
- Reset asserted mid-operation overrides load and flush immediately (asynchronous).
- There are no other states and no internal FSM.

Test Plan:
- Reset: hold rst_n=0 with inputs 8'hFF, toggle clk -> instReg=24'h000000, valid=0. Release rst_n, load=1, next edge -> instReg=24'hFFFFFF, valid=1.
- Staggered fields: load=1, opcode=8'h01 at t0, operando1=8'h01 at t0+10, operando2=8'h01 at t0+20 (clk period 10).
  - Successive edges -> instReg progresses to 24'h01xxxx, then 24'h0101xx, then 24'h010101.
  - Field outputs match the slices at every edge.
- Hold: capture 24'hA5_3C_7E, then load=0 and change inputs to 8'h00 for 5 cycles -> instReg stays 24'hA53C7E, valid=1.
- Flush priority: valid=1 with 24'h123456, assert flush=1 and load=1 with inputs 8'hAA -> next edge instReg=0, valid=0.
- Async reset mid-cycle: valid=1 with 24'h0F0F0F, drop rst_n between edges -> outputs go to 0 before the next clk edge.
- Back-to-back: load=1, inputs 8'h10/8'h20/8'h30 then 8'h40/8'h50/8'h60 on consecutive cycles -> instReg=24'h102030 then 24'h405060 on consecutive edges.
